// File: rtl/aesl_deadlock_track_unit.sv
// Per-process deadlock tracker: merges incoming dependence sets, confirms a
// self-loop over several cycles, reports it once and forwards report tokens.
module aesl_deadlock_track_unit #(
    parameter int unsigned PROC_NUM       = 4,
    parameter int unsigned PROC_ID        = 0,
    parameter int unsigned IN_CHAN_NUM    = 2,
    parameter int unsigned OUT_CHAN_NUM   = 3,
    parameter int unsigned CONFIRM_CYCLES = 4
) (
    input  logic                            reset,
    input  logic                            clock,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    input  logic                            dl_ack,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic                            dl_confirmed,
    output logic [PROC_NUM-1:0]             dl_proc_set,
    output logic [OUT_CHAN_NUM-1:0]         dl_chan_snap
);

    localparam int unsigned       CNT_W     = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CONFIRM_CYCLES);
    localparam logic [CNT_W:0]    CNT_LIM   = (CNT_W + 1)'(CONFIRM_CYCLES);
    localparam logic [PROC_NUM-1:0] ID_ONEHOT = PROC_NUM'(1) << PROC_ID;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONFIRM  = 2'd1,
        REPORTED = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [CNT_W:0]       cnt_inc;
    logic [PROC_NUM-1:0]  dep_reg;
    logic [PROC_NUM-1:0]  dep;
    logic [PROC_NUM-1:0]  dep_acc [IN_CHAN_NUM+1];
    logic                 gate;
    logic                 blocked;
    logic                 cand;
    logic                 report;
    logic                 confirmed_nxt;
    logic                 tok_fwd;

    // OR-reduce the dependence sets of all valid incoming channels
    assign dep_acc[0] = '0;
    for (genvar g = 0; g < IN_CHAN_NUM; g++) begin : g_chan
        assign dep_acc[g+1] = dep_acc[g] |
            (in_chan_dep_vld_vec[g] ? in_chan_dep_data_vec[g*PROC_NUM +: PROC_NUM] : '0);
    end

    // Once a deadlock is known globally, only token-carrying cycles may update dep
    assign gate    = ~dl_detect_in | (|token_in_vec);
    assign blocked = |proc_dep_vld_vec;
    assign dep     = gate ? dep_acc[IN_CHAN_NUM] : dep_reg;
    assign cand    = gate & dep[PROC_ID] & blocked;
    assign tok_fwd = ((|token_in_vec) & ~token_clear) | origin;
    assign cnt_inc = (CNT_W + 1)'(cnt) + (CNT_W + 1)'(1);

    assign out_chan_dep_vld_vec = proc_dep_vld_vec;
    assign out_chan_dep_data    = dep_reg | ID_ONEHOT;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, confirm counter and report strobe
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        report        = 1'b0;
        confirmed_nxt = dl_confirmed;
        unique case (state)
            IDLE: begin
                if (cand) begin
                    cnt_nxt = CNT_W'(1);
                    if (CONFIRM_CYCLES == 1) begin
                        state_nxt = REPORTED;
                        report    = 1'b1;
                    end else begin
                        state_nxt = CONFIRM;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            CONFIRM: begin
                if (!cand) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = (cnt_inc >= CNT_LIM) ? CNT_MAX : cnt_inc[CNT_W-1:0];
                    if (cnt_inc == CNT_LIM) begin
                        state_nxt = REPORTED;
                        report    = 1'b1;
                    end
                end
            end
            REPORTED: begin
                if (dl_ack) begin
                    state_nxt     = IDLE;
                    cnt_nxt       = '0;
                    confirmed_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (report) confirmed_nxt = 1'b1;
    end

    // Dependence register, tokens and report captures
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dep_reg       <= '0;
            token_out_vec <= '0;
            dl_detect_out <= 1'b0;
            dl_confirmed  <= 1'b0;
            dl_proc_set   <= '0;
            dl_chan_snap  <= '0;
        end else begin
            dep_reg       <= blocked ? dep : '0;
            token_out_vec <= tok_fwd ? proc_dep_vld_vec : '0;
            dl_detect_out <= report;
            dl_confirmed  <= confirmed_nxt;
            if (report) begin
                dl_proc_set  <= dep | ID_ONEHOT;
                dl_chan_snap <= proc_dep_vld_vec;
            end
        end
    end

endmodule

// File: doc/aesl_deadlock_track_unit.md
AESL_DEADLOCK_TRACK_UNIT -- requirements
Module: aesl_deadlock_track_unit

Interface
REQ-001 SHALL have parameter PROC_NUM, default 4: number of processes in the dependence graph (>=2).
REQ-002 SHALL have parameter PROC_ID, default 0: index of the owning process (0..PROC_NUM-1).
REQ-003 SHALL have parameter IN_CHAN_NUM, default 2: incoming dependence channels (>=1).
REQ-004 SHALL have parameter OUT_CHAN_NUM, default 3: outgoing dependence channels (>=1).
REQ-005 SHALL have parameter CONFIRM_CYCLES, default 4: consecutive loop-candidate cycles required before deadlock is declared (>=1).
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port clock  input  1  clock; all registers update on the rising edge.
REQ-008 SHALL have port proc_dep_vld_vec  input  OUT_CHAN_NUM  per-channel "process blocked on this channel".
REQ-009 SHALL have port in_chan_dep_vld_vec  input  IN_CHAN_NUM  incoming dependence valid, one bit per channel.
REQ-010 SHALL have port in_chan_dep_data_vec  input  IN_CHAN_NUM*PROC_NUM  incoming dependence sets; channel i occupies bits [i*PROC_NUM +: PROC_NUM].
REQ-011 SHALL have port token_in_vec  input  IN_CHAN_NUM  report tokens from upstream.
REQ-012 SHALL have port dl_detect_in  input  1  global "deadlock already detected".
REQ-013 SHALL have port origin  input  1  this unit originates the report token.
REQ-014 SHALL have port token_clear  input  1  kills token forwarding.
REQ-015 SHALL have port dl_ack  input  1  host acknowledge; releases the REPORTED state.
REQ-016 SHALL have port out_chan_dep_vld_vec  output  OUT_CHAN_NUM  equals proc_dep_vld_vec combinationally.
REQ-017 SHALL have port out_chan_dep_data  output  PROC_NUM  dep_reg OR one-hot(PROC_ID).
REQ-018 SHALL have port token_out_vec  output  OUT_CHAN_NUM  registered forwarded tokens.
REQ-019 SHALL have port dl_detect_out  output  1  registered one-cycle deadlock pulse.
REQ-020 SHALL have port dl_confirmed  output  1  sticky deadlock flag.
REQ-021 SHALL have port dl_proc_set  output  PROC_NUM  captured loop-member set.
REQ-022 SHALL have port dl_chan_snap  output  OUT_CHAN_NUM  captured blocked-channel vector.

Function
REQ-023 SHALL define gate = ~dl_detect_in | (|token_in_vec).
REQ-024 SHALL compute combinational dep = OR over i of (in_chan_dep_vld_vec[i] ? channel i data : 0) when gate=1, else dep = dep_reg.
REQ-025 SHALL load dep_reg <= dep when |proc_dep_vld_vec, else dep_reg <= 0.
REQ-026 SHALL define cand = gate & dep[PROC_ID] & (|proc_dep_vld_vec).
REQ-027 SHALL implement FSM IDLE, CONFIRM, REPORTED; counter cnt of width clog2(CONFIRM_CYCLES+1), saturating at CONFIRM_CYCLES.
REQ-028 IDLE: cand=1 -> cnt<=1; if CONFIRM_CYCLES=1 go REPORTED directly, else go CONFIRM; cand=0 -> stay, cnt<=0.
REQ-029 CONFIRM: cand=0 -> IDLE, cnt<=0; cand=1 -> cnt<=cnt+1; when cnt+1 = CONFIRM_CYCLES -> REPORTED.
REQ-030 On any transition into REPORTED: dl_detect_out<=1 for exactly that one cycle, dl_confirmed<=1, dl_proc_set<=dep | one-hot(PROC_ID), dl_chan_snap<=proc_dep_vld_vec.
REQ-031 REPORTED: cand ignored; capture registers frozen; dl_ack=1 -> IDLE, cnt<=0, dl_confirmed<=0, captures retained until next report.
REQ-032 dl_detect_out SHALL be 0 in every cycle except the transition cycle of REQ-030.
REQ-033 Token: if ((|token_in_vec) & ~token_clear) | origin then token_out_vec <= proc_dep_vld_vec, else 0; origin overrides token_clear.
REQ-034 Token logic SHALL be independent of FSM state.
REQ-035 dl_ack outside REPORTED SHALL have no effect.

Reset
REQ-036 reset=0 SHALL asynchronously force state IDLE, cnt=0, dep_reg=0, token_out_vec=0, dl_detect_out=0, dl_confirmed=0, dl_proc_set=0, dl_chan_snap=0; out_chan_dep_data then equals one-hot(PROC_ID).
REQ-037 Reset during CONFIRM or REPORTED SHALL discard the partial count and captures; no pulse is emitted after release.

Verification (PROC_NUM=4, PROC_ID=1, IN_CHAN_NUM=2, OUT_CHAN_NUM=3, CONFIRM_CYCLES=3)
REQ-038 Reset asserted -> all outputs 0, out_chan_dep_data=4'b0010.
REQ-039 proc_dep_vld_vec=3'b001, ch0 vld data 4'b1010 held -> dl_detect_out single pulse on 3rd edge, dl_proc_set=4'b1010, dl_chan_snap=3'b001, dl_confirmed=1 stays.
REQ-040 Same stimulus with ch0 vld dropped on 2nd cycle -> no pulse; FSM IDLE; three further consecutive cand cycles then required.
REQ-041 dl_detect_in=1, token_in_vec=0 -> dep holds dep_reg, cand=0, no pulse; token_in_vec=2'b01 reopens updates.
REQ-042 origin=1, proc_dep_vld_vec=3'b101 -> token_out_vec=3'b101 next cycle; token_in_vec=2'b10 with token_clear=1, origin=0 -> 3'b000.
REQ-043 In REPORTED, dl_ack=1 -> dl_confirmed=0 next cycle, dl_proc_set retained; cand still held -> new pulse after 3 more cycles.
